// File: rtl/bv8_inv_pipe.sv
// bv8_inv_pipe: three-stage GF(2^8) inverter built on a GF((2^4)^2) normal-basis tower.
// Define BV8_INV_PIPE_AFFINE_EN to add the AES affine transform after the inverse (full S-box).
module bv8_inv_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               in_clock,
  input  logic               in_reset,
  input  logic               in_valid,
  output logic               out_ready_up,
  input  logic [8*LANES-1:0] in_data,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               in_ready_dn,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_busy
);
  localparam int DW = 8 * LANES;
  // GF(2^4) = GF(2)[x]/(x^4+x+1). A tower byte {hi,lo} means hi*Y + lo*Y^16 with
  // Y^2 + Y + LAMBDA = 0, so Y + Y^16 = 1 and Y*Y^16 = LAMBDA (trace(LAMBDA) = 1).
  localparam logic [3:0] LAMBDA = 4'h8;

  function automatic logic [3:0] bv4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, s;
    p = '0;
    s = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] sq_scl(input logic [3:0] a);
    return bv4_mul(LAMBDA, bv4_mul(a, a));
  endfunction

  // a^14 is the inverse for a != 0 and collapses to 0 for a == 0.
  function automatic logic [3:0] bv4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = bv4_mul(a, a);
    a4 = bv4_mul(a2, a2);
    a8 = bv4_mul(a4, a4);
    return bv4_mul(bv4_mul(a8, a4), a2);
  endfunction

  function automatic logic [7:0] tower_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] t;
    t = bv4_mul(LAMBDA, bv4_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]));
    return {bv4_mul(a[7:4], b[7:4]) ^ t, bv4_mul(a[3:0], b[3:0]) ^ t};
  endfunction

  // Column i of a basis-change matrix sits in bits [8i+7:8i].
  function automatic logic [7:0] apply_mat(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (x[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  // Forward map sends x^i to beta^i, beta being a tower root of x^8+x^4+x^3+x+1.
  function automatic logic [63:0] calc_fwd();
    logic [7:0]  beta, b2, b3, b4, b8, p;
    logic [63:0] m;
    logic        found;
    beta  = '0;
    found = 1'b0;
    for (int h = 0; h < 16; h++) begin
      for (int l = 0; l < 16; l++) begin
        p  = {h[3:0], l[3:0]};
        b2 = tower_mul(p, p);
        b3 = tower_mul(b2, p);
        b4 = tower_mul(b2, b2);
        b8 = tower_mul(b4, b4);
        if (!found && ((b8 ^ b4 ^ b3 ^ p ^ 8'h11) == 8'h00)) begin
          beta  = p;
          found = 1'b1;
        end
      end
    end
    m = '0;
    p = 8'h11;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = p;
      p = tower_mul(p, beta);
    end
    return m;
  endfunction

  function automatic logic [63:0] calc_inv(input logic [63:0] fwd);
    logic [63:0] m;
    logic [7:0]  target, p;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      target = 8'h01 << j;
      for (int h = 0; h < 16; h++) begin
        for (int l = 0; l < 16; l++) begin
          p = {h[3:0], l[3:0]};
          if (apply_mat(fwd, p) == target) m[8*j +: 8] = p;
        end
      end
    end
    return m;
  endfunction

`ifdef BV8_INV_PIPE_AFFINE_EN
  function automatic logic [7:0] aes_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction
`endif

  localparam logic [63:0] M_FWD = calc_fwd();
  localparam logic [63:0] M_INV = calc_inv(M_FWD);

  logic                  r_v1, r_v2, r_v3;
  logic [LANES-1:0][3:0] r_hi1, r_lo1, r_d1;
  logic [LANES-1:0][3:0] r_hi2, r_lo2, r_dinv2;
  logic [TAG_W-1:0]      r_tag1, r_tag2, r_tag3;
  logic [DW-1:0]         r_data3;
  logic [LANES-1:0][3:0] w_hi1, w_lo1, w_d1, w_dinv2;
  logic [DW-1:0]         w_data3;
  logic                  w_en1, w_en2, w_en3;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] w_tw_in, w_tw_out, w_poly_out;
    assign w_tw_in    = apply_mat(M_FWD, in_data[8*g +: 8]);
    assign w_hi1[g]   = w_tw_in[7:4];
    assign w_lo1[g]   = w_tw_in[3:0];
    assign w_d1[g]    = sq_scl(w_tw_in[7:4] ^ w_tw_in[3:0]) ^ bv4_mul(w_tw_in[7:4], w_tw_in[3:0]);
    assign w_dinv2[g] = bv4_inv(r_d1[g]);
    // Inverse is the conjugate (halves swapped) scaled by 1/d.
    assign w_tw_out   = {bv4_mul(r_lo2[g], r_dinv2[g]), bv4_mul(r_hi2[g], r_dinv2[g])};
    assign w_poly_out = apply_mat(M_INV, w_tw_out);
`ifdef BV8_INV_PIPE_AFFINE_EN
    assign w_data3[8*g +: 8] = aes_affine(w_poly_out);
`else
    assign w_data3[8*g +: 8] = w_poly_out;
`endif
  end

  // Valid/ready: a beat moves across a boundary on a rising edge where the sender's valid
  // and the receiver's ready are both high; a stage loads when it is empty or its current
  // content leaves in the same cycle, so ready ripples back combinationally from in_ready_dn.
  assign w_en3 = !r_v3 || in_ready_dn;
  assign w_en2 = !r_v2 || w_en3;
  assign w_en1 = !r_v1 || w_en2;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_hi1   <= '0;
      r_lo1   <= '0;
      r_d1    <= '0;
      r_hi2   <= '0;
      r_lo2   <= '0;
      r_dinv2 <= '0;
      r_tag1  <= '0;
      r_tag2  <= '0;
      r_tag3  <= '0;
      r_data3 <= '0;
    end else begin
      if (w_en1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_hi1  <= w_hi1;
          r_lo1  <= w_lo1;
          r_d1   <= w_d1;
          r_tag1 <= in_tag;
        end
      end
      if (w_en2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_hi2   <= r_hi1;
          r_lo2   <= r_lo1;
          r_dinv2 <= w_dinv2;
          r_tag2  <= r_tag1;
        end
      end
      if (w_en3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_data3 <= w_data3;
          r_tag3  <= r_tag2;
        end
      end
    end
  end

  assign out_ready_up = w_en1;
  assign out_valid    = r_v3;
  assign out_data     = r_data3;
  assign out_tag      = r_tag3;
  assign out_busy     = r_v1 || r_v2 || r_v3;
endmodule

// File: doc/bv8_inv_pipe.md
Name: bv8_inv_pipe

Overview:
- Three-stage pipelined GF(2^8) inverter for the S-box datapath.
- Takes LANES bytes per beat in AES polynomial basis and maps them to the package tower-field representation.
- Stage 1 builds the GF(2^4) delta with one bv4_mul per lane. Stage 2 inverts delta in GF(2^4). Stage 3 forms the two GF(2^4) output halves with two bv4_mul per lane and maps the result back to polynomial basis.
- A valid/ready handshake with full backpressure sits between the key-schedule/round logic and the ShiftRows stage.

Parameters:
- LANES, 4, number of independent bytes processed per beat (data width 8*LANES).
- TAG_W, 4, width of opaque sideband tag carried alongside data; 0 not allowed.

Ports:
- in_clock  input  1  clock, all state on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- out_ready_up  output  1  block can accept input this cycle
- in_data  input  8*LANES  bytes, lane i = bits [8i+7:8i], polynomial basis
- in_tag  input  TAG_W  sideband, returned unchanged with the beat
- out_valid  output  1  output beat valid
- in_ready_dn  input  1  downstream accepts output this cycle
- out_data  output  8*LANES  per-lane inverse (or S-box, see feature)
- out_tag  output  TAG_W  tag of the beat on out_data
- out_busy  output  1  OR of the three stage valid bits

Behaviour:
- Reset (in_reset high at a clock edge):
  - All stage valid bits clear; out_valid=0, out_busy=0.
  - out_data and out_tag registers cleared to 0; out_ready_up=1 on the next cycle.
  - Reset mid-operation discards in-flight beats silently.
- Per-lane function: inv(x)=x^254 in GF(2^8) with the AES polynomial 0x11B; inv(0)=0.
- Tower mapping uses the package basis-change matrices in both directions. The tower-field result must equal the polynomial-basis inverse bit-exactly.
- Stage 1, registered:
  - Basis-map in, split into hi/lo nibbles.
  - d = sq_scl(hi^lo) ^ bv4_mul(hi, lo).
  - Register hi, lo, d, tag.
- Stage 2, registered: dinv = GF(2^4) inverse of d, with dinv=0 when d=0. Register hi, lo, dinv, tag.
- Stage 3, registered into output:
  - new_hi = bv4_mul(lo, dinv); new_lo = bv4_mul(hi, dinv).
  - Inverse-map, then register out_data and out_tag.
- No combinational path between stages beyond the listed logic.
- Handshake:
  - Beat accepted when in_valid & out_ready_up.
  - Beat leaves when out_valid & in_ready_dn.
  - Stage k advances when its downstream register is empty or is advancing in the same cycle.
  - out_ready_up = !v1 | advance1 (bubble-collapsing, combinational from in_ready_dn).
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput: one beat/cycle sustained when in_ready_dn=1.
- Stall: while out_valid & !in_ready_dn, out_data and out_tag hold stable. Up to 3 beats are buffered, after which out_ready_up=0.
- Simultaneous accept and emit on a full pipe: allowed; the pipe shifts and occupancy is unchanged.
- Ordering: strictly in order; tags never reordered or duplicated.
- Data registers of invalid stages may hold stale values. out_data is defined only when out_valid=1, except after reset (0).

Optional Feature:
- Macro BV8_INV_PIPE_AFFINE_EN.
- Defined: stage 3 additionally applies the AES affine transform (matrix plus constant 0x63) after the inverse basis change, so out_data = SBox(in_data) per lane. Latency unchanged.
- Undefined: out_data = plain field inverse, with no affine logic present.

Test Plan:
- Directed values, one beat, lanes {0x00,0x01,0x02,0x53}, tag 0x5, in_ready_dn=1 → exactly 3 cycles later out_valid=1.
  - Without feature: lanes {0x00,0x01,0x8D,0xCA}.
  - With feature: {0x63,0x7C,0x77,0xED}.
  - out_tag=0x5.
- Exhaustive streaming: all 256 bytes in every lane position, back-to-back, tag=counter → out_data matches the software inverse (or S-box) per byte, tags consecutive, one beat per cycle, no bubbles.
- Backpressure: hold in_ready_dn=0 and push 5 beats → exactly 3 accepted, then out_ready_up=0.
  - First output stays stable while stalled.
  - Release → beats emerge in order on consecutive cycles; the 4th beat is accepted the same cycle the first leaves.
- Random valid/ready: 10k cycles of random toggling of both sides → scoreboard shows no loss, duplication or reordering. out_busy=0 exactly when the pipe is empty.
- Mid-stream reset: 2 beats in flight, assert in_reset for 1 cycle → next cycle out_valid=0, out_busy=0, out_data=0, out_ready_up=1. The old beats never appear.
- Zero handling: d=0 path (input 0x00) in all lanes, mixed with non-zero lanes in the next beat → zero lanes output 0x00 (0x63 with feature), with no corruption of neighbouring lanes.
